// File: rtl/fsm_alu_unit_if.sv
// Handshake and result bus between the upstream controller and the sequenced ALU.
// The controller side drives operands and strobes; the ALU side returns registered results.
interface fsm_alu_unit_if #(
    parameter int WIDTH = 2
);
    logic             handshaking;
    logic             confirm_op;
    logic [1:0]       switch_op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] alu_result;
    logic             carry;
    logic             zero;
    logic             busy;
    logic [1:0]       state;

    modport master (
        output handshaking,
        output confirm_op,
        output switch_op,
        output operand_a,
        output operand_b,
        input  alu_result,
        input  carry,
        input  zero,
        input  busy,
        input  state
    );

    modport slave (
        input  handshaking,
        input  confirm_op,
        input  switch_op,
        input  operand_a,
        input  operand_b,
        output alu_result,
        output carry,
        output zero,
        output busy,
        output state
    );
endinterface

// File: rtl/fsm_alu_unit.sv
// Small ALU (add/sub/or/and) sequenced by a four-state session FSM.
// Operands are latched on the confirm edge; the result is registered one cycle later and held.
module fsm_alu_unit #(
    parameter int WIDTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fsm_alu_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SELECT  = 2'b01,
        EXECUTE = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;

    // The extra top bit of the widened difference is the borrow, i.e. a < b.
    always_comb begin
        sum_w       = {1'b0, a_q} + {1'b0, b_q};
        diff_w      = {1'b0, a_q} - {1'b0, b_q};
        next_result = '0;
        next_carry  = 1'b0;
        case (op_q)
            2'b00: begin
                next_result = sum_w[WIDTH-1:0];
                next_carry  = sum_w[WIDTH];
            end
            2'b01: begin
                next_result = diff_w[WIDTH-1:0];
                next_carry  = diff_w[WIDTH];
            end
            2'b10: next_result = a_q | b_q;
            default: next_result = a_q & b_q;
        endcase
    end

    // Dropping the session in SELECT wins over a simultaneous confirm.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.handshaking) begin
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (!bus.handshaking) begin
                        state_q <= IDLE;
                    end else if (bus.confirm_op) begin
                        state_q <= EXECUTE;
                        a_q     <= bus.operand_a;
                        b_q     <= bus.operand_b;
                        op_q    <= bus.switch_op;
                    end
                end
                EXECUTE: begin
                    state_q  <= DONE;
                    result_q <= next_result;
                    carry_q  <= next_carry;
                    zero_q   <= (next_result == '0);
                end
                DONE: begin
                    state_q <= bus.handshaking ? SELECT : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_result = result_q;
    assign bus.carry      = carry_q;
    assign bus.zero       = zero_q;
    assign bus.busy       = (state_q == EXECUTE) || (state_q == DONE);
    assign bus.state      = state_q;
endmodule

// File: tb/tb_fsm_alu_unit.sv
// Directed and random scoreboard bench for fsm_alu_unit.
// Expected results are queued when an operation is confirmed and popped when DONE is reached.
module tb_fsm_alu_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [1:0] result;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fsm_alu_unit_if #(.WIDTH(2)) bus ();

    fsm_alu_unit #(.WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic exp_t model(int a, int b, int op);
        exp_t e;
        int   r;
        int   c;
        r = 0;
        c = 0;
        case (op)
            0: begin r = (a + b) % 4; c = (a + b > 3) ? 1 : 0; end
            1: begin r = (a - b + 4) % 4; c = (a < b) ? 1 : 0; end
            2: r = a | b;
            default: r = a & b;
        endcase
        e.result = r[1:0];
        e.carry  = c[0];
        e.zero   = (r == 0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(string tag, logic [3:0] observed, logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(string tag);
        exp_t e;
        checkValue({tag, "_state_done"}, {2'b00, bus.state}, 4'h3);
        checkValue({tag, "_busy"}, {3'b000, bus.busy}, 4'h1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            checkValue({tag, "_result"}, {2'b00, bus.alu_result}, {2'b00, e.result});
            checkValue({tag, "_carry"}, {3'b000, bus.carry}, {3'b000, e.carry});
            checkValue({tag, "_zero"}, {3'b000, bus.zero}, {3'b000, e.zero});
        end
    endtask

    // Confirm in SELECT, scramble inputs after the latching edge, then check at DONE.
    task automatic applyStimulus(string tag, logic [1:0] a, logic [1:0] b, logic [1:0] op);
        bus.operand_a  = a;
        bus.operand_b  = b;
        bus.switch_op  = op;
        bus.confirm_op = 1'b1;
        sb.push_back(model(int'(a), int'(b), int'(op)));
        tick();
        bus.confirm_op = 1'b0;
        bus.operand_a  = ~a;
        bus.operand_b  = ~b;
        bus.switch_op  = ~op;
        checkValue({tag, "_state_exec"}, {2'b00, bus.state}, 4'h2);
        tick();
        checkOutput(tag);
        tick();
        checkValue({tag, "_back_select"}, {2'b00, bus.state}, 4'h1);
    endtask

    initial begin
        logic [1:0] held;
        bus.handshaking = 1'b0;
        bus.confirm_op  = 1'b0;
        bus.switch_op   = 2'b00;
        bus.operand_a   = 2'b00;
        bus.operand_b   = 2'b00;

        #2 reset = 1'b0;
        #1;
        checkValue("rst_state", {2'b00, bus.state}, 4'h0);
        checkValue("rst_result", {2'b00, bus.alu_result}, 4'h0);
        checkValue("rst_zero", {3'b000, bus.zero}, 4'h1);
        checkValue("rst_carry", {3'b000, bus.carry}, 4'h0);
        checkValue("rst_busy", {3'b000, bus.busy}, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        checkValue("idle_stay", {2'b00, bus.state}, 4'h0);

        bus.confirm_op = 1'b1;
        tick();
        bus.confirm_op = 1'b0;
        tick();
        checkValue("idle_ignore_confirm", {2'b00, bus.state}, 4'h0);
        checkValue("idle_result", {2'b00, bus.alu_result}, 4'h0);

        bus.handshaking = 1'b1;
        tick();
        checkValue("enter_select", {2'b00, bus.state}, 4'h1);

        applyStimulus("add_wrap", 2'b11, 2'b11, 2'b00);
        applyStimulus("sub_plain", 2'b11, 2'b01, 2'b01);
        applyStimulus("sub_borrow", 2'b00, 2'b01, 2'b01);
        applyStimulus("or_op", 2'b01, 2'b10, 2'b10);
        applyStimulus("and_zero", 2'b01, 2'b10, 2'b11);
        applyStimulus("and_op", 2'b11, 2'b10, 2'b11);

        held = bus.alu_result;
        repeat (12) tick();
        checkValue("hold_result", {2'b00, bus.alu_result}, {2'b00, held});
        checkValue("hold_state", {2'b00, bus.state}, 4'h1);

        // Abort mid-EXECUTE with an asynchronous reset between edges.
        bus.operand_a  = 2'b01;
        bus.operand_b  = 2'b01;
        bus.switch_op  = 2'b00;
        bus.confirm_op = 1'b1;
        tick();
        bus.confirm_op = 1'b0;
        checkValue("abort_in_exec", {2'b00, bus.state}, 4'h2);
        #2 reset = 1'b0;
        #1;
        checkValue("abort_state", {2'b00, bus.state}, 4'h0);
        checkValue("abort_result", {2'b00, bus.alu_result}, 4'h0);
        checkValue("abort_zero", {3'b000, bus.zero}, 4'h1);
        checkValue("abort_busy", {3'b000, bus.busy}, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        checkValue("abort_reselect", {2'b00, bus.state}, 4'h1);

        applyStimulus("or_before_drop", 2'b01, 2'b10, 2'b10);
        bus.handshaking = 1'b0;
        bus.operand_a   = 2'b01;
        bus.operand_b   = 2'b01;
        bus.switch_op   = 2'b00;
        bus.confirm_op  = 1'b1;
        tick();
        checkValue("drop_state", {2'b00, bus.state}, 4'h0);
        tick();
        checkValue("drop_still_idle", {2'b00, bus.state}, 4'h0);
        checkValue("drop_result", {2'b00, bus.alu_result}, 4'h3);
        bus.confirm_op  = 1'b0;
        bus.handshaking = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            applyStimulus("random", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)));
        end

        checkValue("sb_drained", 4'(sb.size()), 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
